// File: rtl/ser2par_for.sv
// Serial-to-parallel converter: LSB-first shift into an N-bit word with a one-word output slot.
// Optional registered word parity on out_parity when SER2PAR_PARITY_EN is defined.
module ser2par_for #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         sin,
    input  logic         sin_valid,
    output logic         sin_ready,
    output logic [N-1:0] out_word,
    output logic         out_valid,
`ifdef SER2PAR_PARITY_EN
    output logic         out_parity,
`endif
    input  logic         out_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   sreg;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last;
    logic           slot_free;
    logic           load_new;
    logic           load_held;
    logic [N-1:0]   word_new;

    assign sin_ready = (state == FILL);
    assign accept    = sin_valid && sin_ready;
    assign last      = accept && (cnt == CW'(N - 1));
    assign slot_free = !out_valid || out_ready;
    assign load_new  = last && slot_free;
    assign load_held = (state == FULL) && out_ready;

    // The word as it will look once the incoming bit is shifted in.
    assign word_new = {sin, sreg[N-1:1]};

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: if (last && !slot_free) state_nx = FULL;
            FULL: if (out_ready) state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FILL;
        end else if (clr) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clr) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            for (int i = 0; i < N - 1; i++) begin
                sreg[i] <= sreg[i+1];
            end
            sreg[N-1] <= sin;
            cnt       <= last ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_word  <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (load_new) begin
            out_word  <= word_new;
            out_valid <= 1'b1;
        end else if (load_held) begin
            out_word  <= sreg;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SER2PAR_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_parity <= 1'b0;
        end else if (clr) begin
            out_parity <= 1'b0;
        end else if (load_new) begin
            out_parity <= ^word_new;
        end else if (load_held) begin
            out_parity <= ^sreg;
        end
    end
`endif

endmodule

// File: tb/tb_ser2par_for.sv
// Bench for ser2par_for at N=4: vector table, streaming run and hand-written corner sequences.
// Word results are checked through a scoreboard queue popped on each output transfer.
module tb_ser2par_for;

    localparam int N = 4;

    logic         clk;
    logic         rstn;
    logic         clr;
    logic         sin;
    logic         sin_valid;
    logic         sin_ready;
    logic [N-1:0] out_word;
    logic         out_valid;
    logic         out_ready;
`ifdef SER2PAR_PARITY_EN
    logic         out_parity;
`endif

    ser2par_for #(.N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
`ifdef SER2PAR_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic [0:3] seq;
        logic [3:0] word;
        int         gap;
    } vec_t;

    vec_t       vecs[8];
    logic [3:0] q[$];
    int         tests;
    int         fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a word leaves the DUT whenever out_valid && out_ready.
    always @(negedge clk) begin
        if (rstn && !clr && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(out_word), 32'hdead);
            end else begin
                chk("sb_word", 32'(out_word), 32'(q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int t;
        sin       = b;
        sin_valid = 1'b1;
        for (t = 0; t < 20 && !sin_ready; t++) step();
        if (!sin_ready) chk("accept_timeout", 32'(sin_ready), 32'd1);
        else step();
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        repeat (n) step();
    endtask

    logic [15:0] stream;

    initial begin
        tests     = 0;
        fails     = 0;
        rstn      = 1'b0;
        clr       = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{seq: 4'b1011, word: 4'b1101, gap: 0};
        vecs[1] = '{seq: 4'b1000, word: 4'b0001, gap: 0};
        vecs[2] = '{seq: 4'b0111, word: 4'b1110, gap: 2};
        vecs[3] = '{seq: 4'b0010, word: 4'b0100, gap: 1};
        vecs[4] = '{seq: 4'b1111, word: 4'b1111, gap: 0};
        vecs[5] = '{seq: 4'b0000, word: 4'b0000, gap: 3};
        vecs[6] = '{seq: 4'b1001, word: 4'b1001, gap: 0};
        vecs[7] = '{seq: 4'b0110, word: 4'b0110, gap: 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sin_ready", 32'(sin_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", 32'(out_word), 32'd0);
`ifdef SER2PAR_PARITY_EN
        chk("rst_parity", 32'(out_parity), 32'd0);
`endif
        rstn      = 1'b1;
        out_ready = 1'b1;
        step();

        // Table: one word per record, optional idle gaps between bits.
        foreach (vecs[r]) begin
            for (int b = 0; b < 4; b++) begin
                send_bit(vecs[r].seq[b]);
                if (b < 3 && vecs[r].gap > 0) begin
                    sin_valid = 1'b0;
                    sin       = ~sin;
                    repeat (vecs[r].gap) step();
                end
            end
            sin_valid = 1'b0;
            q.push_back(vecs[r].word);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_word", 32'(out_word), 32'(vecs[r].word));
`ifdef SER2PAR_PARITY_EN
            chk("vec_parity", 32'(out_parity), 32'(^vecs[r].word));
`endif
        end

        // Continuous stream, out_ready held high.
        stream = 16'($urandom);
        for (int k = 0; k < 16; k++) begin
            sin       = stream[k];
            sin_valid = 1'b1;
            chk("stream_ready", 32'(sin_ready), 32'd1);
            step();
            if (k % 4 == 3) q.push_back(stream[k-3 +: 4]);
            chk("stream_valid", 32'(out_valid), 32'(k % 4 == 3));
        end
        idle(1);

        // Busy slot: second word parks in FULL until out_ready rises.
        out_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        q.push_back(4'b0001);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        q.push_back(4'b1110);
        sin_valid = 1'b0;
        chk("full_sin_ready", 32'(sin_ready), 32'd0);
        chk("full_word", 32'(out_word), 32'h1);
        idle(3);
        chk("hold_word", 32'(out_word), 32'h1);
        chk("hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("drain_word", 32'(out_word), 32'he);
        chk("drain_valid", 32'(out_valid), 32'd1);
        chk("drain_ready", 32'(sin_ready), 32'd1);
        step();
        chk("drain_clear", 32'(out_valid), 32'd0);

        // clr discards a held word.
        out_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        sin_valid = 1'b0;
        q.push_back(4'b1011);
        chk("held_valid", 32'(out_valid), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        q.delete();
        chk("clr_held_valid", 32'(out_valid), 32'd0);

        // clr mid-word beats a simultaneous accept.
        out_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        clr       = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        step();
        clr       = 1'b0;
        sin_valid = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'd0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        sin_valid = 1'b0;
        q.push_back(4'b0100);
        chk("clr_next_word", 32'(out_word), 32'h4);
        chk("clr_next_valid", 32'(out_valid), 32'd1);
        idle(1);

        // Asynchronous reset mid-word with a held word present.
        out_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        sin_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_word", 32'(out_word), 32'd0);
        chk("arst_ready", 32'(sin_ready), 32'd1);
`ifdef SER2PAR_PARITY_EN
        chk("arst_parity", 32'(out_parity), 32'd0);
`endif
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        sin_valid = 1'b0;
        q.push_back(4'b0111);
        chk("post_rst_word", 32'(out_word), 32'h7);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        idle(3);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
